// File: rtl/i2c_target_pkg.sv
// -----------------------------------------------------------------------------
// i2c_target_pkg
// Shared types and constants for the I2C target register port.
//   state_t              protocol state machine encoding
//   TARGET_ADDR_DEFAULT  default 7-bit bus address
//   RW_BIT               position of the R/W flag in the address byte
//   BITS_PER_BYTE        data bits between ACK slots
// -----------------------------------------------------------------------------
package i2c_target_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK
   } state_t;

   localparam logic [6:0] TARGET_ADDR_DEFAULT = 7'h70;
   localparam int         RW_BIT              = 0;
   localparam int         BITS_PER_BYTE       = 8;

endpackage

// File: rtl/i2c_pin_sync.sv
// -----------------------------------------------------------------------------
// i2c_pin_sync
// Synchronises the raw SDA/SCL pins into the clk domain and derives bus events.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sda_in, scl_in    raw pin levels
//   sda, scl          synchronised levels
//   scl_rise/fall     one-cycle pulses on synchronised SCL edges
//   start_det         one-cycle pulse: SDA fell while SCL high
//   stop_det          one-cycle pulse: SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sda_in,
   input  logic scl_in,
   output logic sda,
   output logic scl,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] sda_sync;
   logic [SYNC_STAGES-1:0] scl_sync;
   logic                   sda_prev;
   logic                   scl_prev;

   // Chains reset to 1 (idle bus level) so leaving reset never fakes an event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sda_sync <= '1;
         scl_sync <= '1;
         sda_prev <= 1'b1;
         scl_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments let each flop take the previous
         // stage's old value; blocking would collapse the chain to one flop.
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_prev <= sda;
         scl_prev <= scl;
      end
   end

   assign sda = sda_sync[SYNC_STAGES-1];
   assign scl = scl_sync[SYNC_STAGES-1];

   assign scl_rise  = scl & ~scl_prev;
   assign scl_fall  = ~scl & scl_prev;
   // SCL must be high on both samples so an SDA change near an SCL edge
   // is never mistaken for START/STOP.
   assign start_det = scl & scl_prev & sda_prev & ~sda;
   assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target_regport.sv
// -----------------------------------------------------------------------------
// i2c_target_regport
// I2C target that bridges bus transactions to an 8-bit register port.
// Write: [addr W] [pointer] [data]*   Read: [addr W] [pointer] Sr [addr R] [data]*
// The pointer auto-increments after every data byte. SDA is only ever pulled
// low; SCL is never driven.
// Ports:
//   clk, rst     system clock (>= 16x SCL), asynchronous active-high reset
//   sda_in       raw SDA pin level
//   scl_in       raw SCL pin level
//   sda_oe       1 = pull SDA low
//   reg_addr     current register pointer
//   reg_wdata    write data, valid while reg_we is high
//   reg_we       one-cycle write strobe
//   reg_re       one-cycle read strobe; reg_rdata captured in the same cycle
//   reg_rdata    read data for reg_addr
//   busy         addressed transaction in progress
// -----------------------------------------------------------------------------
module i2c_target_regport
   import i2c_target_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = TARGET_ADDR_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sda_in,
   input  logic       scl_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic sda;
   logic scl;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   i2c_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clk       (clk),
      .rst       (rst),
      .sda_in    (sda_in),
      .scl_in    (scl_in),
      .sda       (sda),
      .scl       (scl),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   state_t     state,     state_n;
   logic [2:0] bit_cnt,   bit_cnt_n;
   logic [7:0] shift,     shift_n;
   logic       rw,        rw_n;
   logic       load_pend, load_pend_n;
   logic       sda_oe_n;
   logic [7:0] reg_addr_n;
   logic [7:0] reg_wdata_n;
   logic       reg_we_n;
   logic       busy_n;

   logic [7:0] byte_in;
   logic       last_bit;

   assign byte_in  = {shift[6:0], sda};
   assign last_bit = (bit_cnt == 3'(BITS_PER_BYTE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         rw        <= 1'b0;
         load_pend <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         rw        <= rw_n;
         load_pend <= load_pend_n;
         sda_oe    <= sda_oe_n;
         reg_addr  <= reg_addr_n;
         reg_wdata <= reg_wdata_n;
         reg_we    <= reg_we_n;
         busy      <= busy_n;
      end
   end

   // In every *_ACK state sda_oe doubles as the phase flag: the first SCL
   // fall starts driving the ACK, the second one (sda_oe already set) ends it.
   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can
      // leave a signal unassigned and infer a latch.
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      rw_n        = rw;
      load_pend_n = load_pend;
      sda_oe_n    = sda_oe;
      reg_addr_n  = reg_addr;
      reg_wdata_n = reg_wdata;
      reg_we_n    = 1'b0;
      reg_re      = 1'b0;
      busy_n      = busy;

      if (stop_det) begin
         state_n     = IDLE;
         sda_oe_n    = 1'b0;
         busy_n      = 1'b0;
         load_pend_n = 1'b0;
      end else if (start_det) begin
         // Repeated START keeps reg_addr and busy; the address phase decides.
         state_n     = ADDR;
         bit_cnt_n   = '0;
         sda_oe_n    = 1'b0;
         load_pend_n = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;

            ADDR: if (scl_rise) begin
               shift_n   = byte_in;
               bit_cnt_n = bit_cnt + 3'd1;
               if (last_bit) begin
                  bit_cnt_n = '0;
                  if (byte_in[7:1] == TARGET_ADDR) begin
                     state_n = ADDR_ACK;
                     rw_n    = byte_in[RW_BIT];
                     busy_n  = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end

            ADDR_ACK: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else if (rw) begin
                  // First read byte is fetched on the fall that ends the ACK.
                  reg_re    = 1'b1;
                  shift_n   = reg_rdata;
                  sda_oe_n  = ~reg_rdata[7];
                  bit_cnt_n = '0;
                  state_n   = RDATA;
               end else begin
                  sda_oe_n = 1'b0;
                  state_n  = PTR;
               end
            end

            PTR: if (scl_rise) begin
               shift_n   = byte_in;
               bit_cnt_n = bit_cnt + 3'd1;
               if (last_bit) begin
                  bit_cnt_n  = '0;
                  reg_addr_n = byte_in;
                  state_n    = PTR_ACK;
               end
            end

            PTR_ACK: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else begin
                  sda_oe_n = 1'b0;
                  state_n  = WDATA;
               end
            end

            WDATA: if (scl_rise) begin
               shift_n   = byte_in;
               bit_cnt_n = bit_cnt + 3'd1;
               if (last_bit) begin
                  bit_cnt_n   = '0;
                  reg_wdata_n = byte_in;
                  reg_we_n    = 1'b1;
                  state_n     = WDATA_ACK;
               end
            end

            WDATA_ACK: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else begin
                  sda_oe_n   = 1'b0;
                  reg_addr_n = reg_addr + 8'd1;
                  state_n    = WDATA;
               end
            end

            // Bit 7 is already on the wire at entry; each fall presents the
            // next bit, and the eighth fall releases SDA for the master's ACK.
            RDATA: if (scl_fall) begin
               if (last_bit) begin
                  sda_oe_n  = 1'b0;
                  bit_cnt_n = '0;
                  state_n   = RDATA_ACK;
               end else begin
                  sda_oe_n  = ~shift[6];
                  shift_n   = {shift[6:0], 1'b0};
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end

            RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda) begin
                     reg_addr_n  = reg_addr + 8'd1;
                     load_pend_n = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end else if (scl_fall && load_pend) begin
                  load_pend_n = 1'b0;
                  reg_re      = 1'b1;
                  shift_n     = reg_rdata;
                  sda_oe_n    = ~reg_rdata[7];
                  bit_cnt_n   = '0;
                  state_n     = RDATA;
               end
            end

            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target_regport.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regport
// Bus-master model driving i2c_target_regport through write, read, wrong
// address, aborted-byte and mid-read reset scenarios. The register file is
// modelled as reg_rdata = ~reg_addr.
// -----------------------------------------------------------------------------
module tb_i2c_target_regport;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       msda = 1'b1;
   logic       mscl = 1'b1;
   logic       sda_in;
   logic       scl_in;
   logic       sda_oe;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;

   // Open-drain bus: either side can pull SDA low.
   assign sda_in    = msda & ~sda_oe;
   assign scl_in    = mscl;
   assign reg_rdata = ~reg_addr;

   always #5ns clk = ~clk;

   i2c_target_regport dut (
      .clk       (clk),
      .rst       (rst),
      .sda_in    (sda_in),
      .scl_in    (scl_in),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Strobe monitors, sampled mid-cycle.
   logic [15:0] wq[$];
   int          re_cnt   = 0;
   int          oe_cnt   = 0;
   int          busy_cnt = 0;

   always @(negedge clk) begin
      if (reg_we) wq.push_back({reg_addr, reg_wdata});
      if (reg_re) re_cnt++;
      if (sda_oe) oe_cnt++;
      if (busy)   busy_cnt++;
   end

   // Quarter SCL period = 8 clk, so SCL runs at clk/32.
   task automatic qwait();
      #80ns;
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      msda = b;
      qwait();
      mscl = 1'b1;
      qwait();
      s = sda_in;
      qwait();
      mscl = 1'b0;
      qwait();
   endtask

   task automatic i2c_start();
      msda = 1'b1;
      qwait();
      mscl = 1'b1;
      qwait();
      msda = 1'b0;
      qwait();
      mscl = 1'b0;
      qwait();
   endtask

   task automatic i2c_stop();
      msda = 1'b0;
      qwait();
      mscl = 1'b1;
      qwait();
      msda = 1'b1;
      qwait();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(~mack, s);
   endtask

   typedef struct {
      logic [7:0]  ptr;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  end_addr;
   } wr_vec_t;

   wr_vec_t vecs[3];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      int         acks;
      int         wbase;
      int         rbase;
      int         obase;
      int         bbase;
      logic [7:0] rd;

      vecs[0] = '{ptr: 8'h0A, d0: 8'h55, d1: 8'h1F, w0: 16'h0A55, w1: 16'h0B1F, end_addr: 8'h0C};
      vecs[1] = '{ptr: 8'h7F, d0: 8'hFA, d1: 8'h4D, w0: 16'h7FFA, w1: 16'h804D, end_addr: 8'h81};
      vecs[2] = '{ptr: 8'hFF, d0: 8'h12, d1: 8'h34, w0: 16'hFF12, w1: 16'h0034, end_addr: 8'h01};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sda_oe",    32'(sda_oe),    32'h0);
      check("rst_reg_addr",  32'(reg_addr),  32'h00);
      check("rst_reg_wdata", 32'(reg_wdata), 32'h00);
      check("rst_reg_we",    32'(reg_we),    32'h0);
      check("rst_reg_re",    32'(reg_re),    32'h0);
      check("rst_busy",      32'(busy),      32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven write transactions
      for (int v = 0; v < 3; v++) begin
         wbase = wq.size();
         acks  = 0;
         i2c_start();
         send_byte(8'hE0, ack); acks += int'(ack);
         check($sformatf("wr%0d_busy_on", v), 32'(busy), 32'h1);
         send_byte(vecs[v].ptr, ack); acks += int'(ack);
         send_byte(vecs[v].d0, ack);  acks += int'(ack);
         send_byte(vecs[v].d1, ack);  acks += int'(ack);
         i2c_stop();
         repeat (4) @(negedge clk);
         check($sformatf("wr%0d_acks", v),     32'(acks),                32'd4);
         check($sformatf("wr%0d_nwrites", v),  32'(wq.size() - wbase),   32'd2);
         check($sformatf("wr%0d_w0", v),       32'(wq[wbase]),           32'(vecs[v].w0));
         check($sformatf("wr%0d_w1", v),       32'(wq[wbase + 1]),       32'(vecs[v].w1));
         check($sformatf("wr%0d_end_addr", v), 32'(reg_addr),            32'(vecs[v].end_addr));
         check($sformatf("wr%0d_busy_off", v), 32'(busy),                32'h0);
      end

      // Read: pointer 0x7E, repeated START, two bytes (ACK then NAK)
      rbase = re_cnt;
      i2c_start();
      send_byte(8'hE0, ack);
      send_byte(8'h7E, ack);
      i2c_start();
      send_byte(8'hE1, ack);
      check("rd_addr_ack", 32'(ack), 32'h1);
      recv_byte(1'b1, rd);
      check("rd_byte0", 32'(rd), 32'h81);
      recv_byte(1'b0, rd);
      check("rd_byte1", 32'(rd), 32'h80);
      check("rd_sda_released", 32'(sda_oe), 32'h0);
      check("rd_busy_after_nak", 32'(busy), 32'h0);
      check("rd_addr_after_nak", 32'(reg_addr), 32'h7F);
      check("rd_re_pulses", 32'(re_cnt - rbase), 32'd2);
      i2c_stop();
      repeat (4) @(negedge clk);

      // Wrong address: nothing on the bus or the register port
      wbase = wq.size();
      obase = oe_cnt;
      bbase = busy_cnt;
      acks  = 0;
      i2c_start();
      send_byte(8'hE2, ack); acks += int'(ack);
      send_byte(8'h33, ack); acks += int'(ack);
      send_byte(8'h44, ack); acks += int'(ack);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("wa_acks",     32'(acks),                32'd0);
      check("wa_sda_oe",   32'(oe_cnt - obase),      32'd0);
      check("wa_writes",   32'(wq.size() - wbase),   32'd0);
      check("wa_busy",     32'(busy_cnt - bbase),    32'd0);

      // STOP after four bits of a data byte, then a normal write
      wbase = wq.size();
      i2c_start();
      send_byte(8'hE0, ack);
      send_byte(8'h20, ack);
      bit_xfer(1'b1, ack);
      bit_xfer(1'b0, ack);
      bit_xfer(1'b1, ack);
      bit_xfer(1'b1, ack);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("ab_writes", 32'(wq.size() - wbase), 32'd0);
      check("ab_busy",   32'(busy),              32'h0);
      check("ab_addr",   32'(reg_addr),          32'h20);
      acks = 0;
      i2c_start();
      send_byte(8'hE0, ack); acks += int'(ack);
      send_byte(8'h30, ack); acks += int'(ack);
      send_byte(8'hA5, ack); acks += int'(ack);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("ab_next_acks",   32'(acks),                32'd3);
      check("ab_next_writes", 32'(wq.size() - wbase),   32'd1);
      check("ab_next_w0",     32'(wq[wbase]),           32'h30A5);

      // Reset while the target pulls SDA for a read data bit
      i2c_start();
      send_byte(8'hE0, ack);
      send_byte(8'hC3, ack);
      i2c_start();
      send_byte(8'hE1, ack);
      check("rr_driving_bit", 32'(sda_oe), 32'h1);
      @(posedge clk);
      #2ns rst = 1'b1;
      #1ns;
      check("rr_sda_oe",    32'(sda_oe),    32'h0);
      check("rr_reg_addr",  32'(reg_addr),  32'h00);
      check("rr_reg_wdata", 32'(reg_wdata), 32'h00);
      check("rr_reg_we",    32'(reg_we),    32'h0);
      check("rr_reg_re",    32'(reg_re),    32'h0);
      check("rr_busy",      32'(busy),      32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      wbase = wq.size();
      i2c_start();
      send_byte(8'hE0, ack);
      check("rr_next_ack", 32'(ack), 32'h1);
      send_byte(8'h44, ack);
      send_byte(8'h99, ack);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("rr_next_w0", 32'(wq[wbase]), 32'h4499);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
